// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and width limits.
package usr_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/d_ff_ar.sv
// Single-bit rising-edge D flop with asynchronous active-high reset and complementary output.
module d_ff_ar #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic q_not
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

  // Derived from the same flop so the pair can never disagree.
  assign q_not = ~q;

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register: hold, shift right, shift left, parallel load.
// Optional rotate input ROT is enabled by defining USR_ROTATE_EN.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned         WIDTH     = 8,
  parameter logic [WIDTH-1:0]    RESET_VAL = {WIDTH{1'b0}}
) (
`ifdef USR_ROTATE_EN
  input  logic             ROT,
`endif
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             SIN_R,
  input  logic             SIN_L,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_not,
  output logic             SOUT_R,
  output logic             SOUT_L
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] shr_vec;
  logic [WIDTH-1:0] shl_vec;
  logic             sin_r_eff;
  logic             sin_l_eff;

  // With rotation the bit falling off one end re-enters at the other.
`ifdef USR_ROTATE_EN
  assign sin_r_eff = ROT ? q[0]       : SIN_R;
  assign sin_l_eff = ROT ? q[WIDTH-1] : SIN_L;
`else
  assign sin_r_eff = SIN_R;
  assign sin_l_eff = SIN_L;
`endif

  assign shr_vec = {sin_r_eff, q[WIDTH-1:1]};
  assign shl_vec = {q[WIDTH-2:0], sin_l_eff};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic nxt;

    // Per-bit 4:1 next-state mux; EN low forces hold.
    always_comb begin
      nxt = q[i];
      if (EN) begin
        case (mode_e'(MODE))
          MODE_SHR:  nxt = shr_vec[i];
          MODE_SHL:  nxt = shl_vec[i];
          MODE_LOAD: nxt = D[i];
          default:   nxt = q[i];
        endcase
      end
    end

    d_ff_ar #(
      .RST_VAL (RESET_VAL[i])
    ) u_ff (
      .clk   (CLK),
      .rst   (RST),
      .d     (nxt),
      .q     (q[i]),
      .q_not (qn[i])
    );
  end

  assign Q      = q;
  assign Q_not  = qn;
  assign SOUT_R = q[0];
  assign SOUT_L = q[WIDTH-1];

endmodule
